// File: rtl/io_pkg.sv
// Shared constants for the core-to-UART byte buffer: default FIFO depth and
// the bit layout of the io_status debug word.
// Also provides a helper that widens a byte onto the 32-bit core data bus.
package io_pkg;

  // log2 of the entries in each of the TX and RX FIFOs
  localparam int IO_DEPTH_LOG2_DEFAULT = 10;

  // io_status field positions
  localparam int RX_CNT_LSB = 0;
  localparam int TX_CNT_LSB = 16;
  localparam int OVF_BIT    = 31;

  // Zero-extend a byte onto the 32-bit core data bus
  function automatic logic [31:0] zext_byte(input logic [7:0] b);
    return {24'b0, b};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with first-word-fall-through head (dout = entry at rd_ptr).
// Latency: a push into an empty FIFO is visible and poppable on the next cycle.
// Backpressure: push refused when full (even with a same-cycle pop), pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  push_ok;
  logic                  pop_ok;

  // Full/empty come only from the registered count, so a same-cycle pop
  // never frees a slot for a push and a same-cycle push never feeds a pop.
  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign count   = cnt;
  assign dout    = mem[rd_ptr];

  // Storage: written on accepted push; contents are don't-care until counted
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo depth
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/io_buffer.sv
// Byte buffer between the core I/O port and the UART TX/RX engines (one FIFO each way).
// Latency: 1 cycle push-to-pop in each direction; in_data/tx_data are FWFT heads.
// Backpressure: core stalls on TX full / RX empty; UART RX has none, so bytes arriving when full are dropped and flagged.
module io_buffer
  import io_pkg::*;
#(
  parameter int DEPTH_LOG2 = IO_DEPTH_LOG2_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        out_issued,
  input  logic [31:0] out_data,
  output logic        out_stall,
  input  logic        in_issued,
  output logic        in_stall,
  output logic [31:0] in_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] io_status
);

  logic [7:0]          tx_head;
  logic                tx_full;
  logic                tx_empty;
  logic [DEPTH_LOG2:0] tx_count;
  logic                tx_push;
  logic                tx_pop;

  logic [7:0]          rx_head;
  logic                rx_full;
  logic                rx_empty;
  logic [DEPTH_LOG2:0] rx_count;
  logic                rx_push;
  logic                rx_pop;

  logic                rx_overflow;
  logic                unused_out_hi;

  // Only the low byte of a core write is transmitted
  assign unused_out_hi = ^out_data[31:8];

  // Stalls depend only on core requests and registered FIFO state,
  // never on tx_ready or rx_valid, so no UART-to-core combinational path.
  assign out_stall = out_issued & tx_full;
  assign in_stall  = in_issued & rx_empty;

  assign tx_push = out_issued & ~tx_full;
  assign tx_pop  = tx_valid & tx_ready;
  assign rx_push = rx_valid;
  assign rx_pop  = in_issued & ~rx_empty;

  // Heads are masked while empty so stale storage never reaches either side
  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_empty ? 8'h00 : tx_head;
  assign in_data  = rx_empty ? 32'h0 : zext_byte(rx_head);

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (out_data[7:0]),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // Sticky overflow: any receiver strobe while RX is full loses a byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_overflow <= 1'b0;
    end else if (rx_valid && rx_full) begin
      rx_overflow <= 1'b1;
    end
  end

  // Pack registered counts and the overflow flag into the debug word
  always_comb begin
    io_status = 32'h0;
    io_status[RX_CNT_LSB +: DEPTH_LOG2+1] = rx_count;
    io_status[TX_CNT_LSB +: DEPTH_LOG2+1] = tx_count;
    io_status[OVF_BIT] = rx_overflow;
  end

endmodule

// File: tb/tb_io_buffer.sv
// Directed test for io_buffer with a queue scoreboard; monitor compares TX and core-read data.
module tb_io_buffer;

  localparam int DL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        out_issued = 1'b0;
  logic [31:0] out_data = 32'h0;
  logic        out_stall;
  logic        in_issued = 1'b0;
  logic        in_stall;
  logic [31:0] in_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic [31:0] io_status;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  io_buffer #(.DEPTH_LOG2(DL)) dut (
    .clk        (clk),
    .rst        (rst),
    .out_issued (out_issued),
    .out_data   (out_data),
    .out_stall  (out_stall),
    .in_issued  (in_issued),
    .in_stall   (in_stall),
    .in_data    (in_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .io_status  (io_status)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares presented TX head and completed core reads against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (tx_valid) begin
          if (tx_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got 0x%02h expected no byte", tx_data);
          end else begin
            check32("tx_data", {24'b0, tx_data}, {24'b0, tx_exp[0]});
            if (tx_ready) void'(tx_exp.pop_front());
          end
        end
        if (in_issued && !in_stall) begin
          if (rx_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got 0x%08h expected no read", in_data);
          end else begin
            check32("in_data", in_data, {24'b0, rx_exp[0]});
            void'(rx_exp.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] wdat [3];
    logic [7:0]  b;
    int          n;
    wdat[0] = 32'h12345678;
    wdat[1] = 32'h000000AA;
    wdat[2] = 32'h00000055;

    // ---- reset state ----
    step();
    check32("rst_io_status", io_status, 32'h0);
    check32("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check32("rst_in_stall", {31'b0, in_stall}, 32'h0);
    check32("rst_out_stall", {31'b0, out_stall}, 32'h0);
    check32("rst_in_data", in_data, 32'h0);
    step();
    rst = 1'b1;
    step();

    // ---- read from empty stalls until a byte arrives ----
    in_issued = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check32("empty_in_stall", {31'b0, in_stall}, 32'h1);
      step();
    end
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    rx_exp.push_back(8'h41);
    #1 check32("push_read_same_cycle_stall", {31'b0, in_stall}, 32'h1);
    step();
    rx_valid = 1'b0;
    #1 check32("read_next_cycle_stall", {31'b0, in_stall}, 32'h0);
    check32("read_next_cycle_data", in_data, 32'h00000041);
    step();
    in_issued = 1'b0;
    #1 check32("after_read_status", io_status, 32'h0);
    check32("after_read_in_data", in_data, 32'h0);

    // ---- TX burst with tx_ready every other cycle ----
    for (int i = 0; i < 3; i++) begin
      out_issued = 1'b1;
      out_data   = wdat[i];
      tx_ready   = (i % 2) == 1;
      tx_exp.push_back(wdat[i][7:0]);
      #1 check32("burst_out_stall", {31'b0, out_stall}, 32'h0);
      step();
    end
    out_issued = 1'b0;
    n = 3;
    while (io_status[18:16] != 3'd0 && n < 23) begin
      tx_ready = (n % 2) == 1;
      step();
      n++;
    end
    tx_ready = 1'b0;
    #1 check32("burst_tx_count", {29'b0, io_status[18:16]}, 32'h0);
    check32("burst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check32("burst_tx_exp_left", tx_exp.size(), 32'h0);

    // ---- TX full: fifth write stalls, even across a same-cycle pop ----
    for (int i = 0; i < 4; i++) begin
      b = 8'hB0 + 8'(i);
      out_issued = 1'b1;
      out_data   = {24'hC0DE00, b};
      tx_exp.push_back(b);
      #1 check32("fill_out_stall", {31'b0, out_stall}, 32'h0);
      step();
    end
    out_data = 32'hC0DE00B4;
    #1 check32("full_out_stall", {31'b0, out_stall}, 32'h1);
    check32("full_tx_count", {29'b0, io_status[18:16]}, 32'h4);
    step();
    #1 check32("full_out_stall_held", {31'b0, out_stall}, 32'h1);
    step();
    tx_ready = 1'b1;
    #1 check32("full_pop_push_refused", {31'b0, out_stall}, 32'h1);
    step();
    tx_ready = 1'b0;
    tx_exp.push_back(8'hB4);
    #1 check32("after_pop_out_stall", {31'b0, out_stall}, 32'h0);
    step();
    out_issued = 1'b0;
    #1 check32("final_tx_count", {29'b0, io_status[18:16]}, 32'h4);
    tx_ready = 1'b1;
    n = 0;
    while (io_status[18:16] != 3'd0 && n < 10) begin
      step();
      n++;
    end
    tx_ready = 1'b0;
    #1 check32("drain_tx_count", {29'b0, io_status[18:16]}, 32'h0);
    check32("drain_tx_exp_left", tx_exp.size(), 32'h0);

    // ---- RX overflow: five strobes, four kept ----
    for (int i = 1; i <= 5; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(i);
      if (i <= 4) rx_exp.push_back(8'(i));
      step();
    end
    rx_valid = 1'b0;
    #1 check32("ovf_status", io_status, 32'h80000004);
    in_issued = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check32("ovf_read_stall", {31'b0, in_stall}, 32'h0);
      step();
    end
    #1 check32("fifth_read_stall", {31'b0, in_stall}, 32'h1);
    in_issued = 1'b0;
    #1 check32("ovf_sticky_status", io_status, 32'h80000000);

    // ---- async reset mid-burst with TX count 3 ----
    step();
    for (int i = 0; i < 3; i++) begin
      b = 8'hC1 + 8'(i);
      out_issued = 1'b1;
      out_data   = {24'h0, b};
      tx_exp.push_back(b);
      step();
    end
    out_data = 32'h000000C4;
    #1 check32("pre_reset_status", io_status, 32'h80030000);
    #1;
    rst        = 1'b0;
    out_issued = 1'b0;
    tx_exp.delete();
    #1 check32("async_rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check32("async_rst_status", io_status, 32'h0);
    check32("async_rst_tx_data", {24'b0, tx_data}, 32'h0);
    step();
    step();
    rst      = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check32("post_rst_tx_valid", {31'b0, tx_valid}, 32'h0);
      step();
    end
    tx_ready = 1'b0;

    // ---- full RX with simultaneous strobe and pop ----
    for (int i = 0; i < 4; i++) begin
      b = 8'h11 + 8'(i);
      rx_valid = 1'b1;
      rx_data  = b;
      rx_exp.push_back(b);
      step();
    end
    rx_valid = 1'b0;
    #1 check32("rx_full_status", io_status, 32'h00000004);
    rx_valid  = 1'b1;
    rx_data   = 8'h99;
    in_issued = 1'b1;
    #1 check32("full_pop_in_stall", {31'b0, in_stall}, 32'h0);
    step();
    rx_valid  = 1'b0;
    in_issued = 1'b0;
    #1 check32("full_pop_push_status", io_status, 32'h80000003);
    in_issued = 1'b1;
    repeat (3) step();
    #1 check32("dropped_byte_absent", {31'b0, in_stall}, 32'h1);
    in_issued = 1'b0;
    step();
    check32("rx_exp_left", rx_exp.size(), 32'h0);
    check32("tx_exp_left", tx_exp.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_buffer.md
Name: io_buffer

Overview:
- Sits between the pipeline core's I/O port (out_issued/out_data/in_issued, out_stall/in_stall/in_data) and the byte-wide UART TX/RX engines.
- Buffers core output bytes in a TX FIFO and received bytes in an RX FIFO.
- Generates the core's stall signals when a FIFO cannot serve a request.
- Exposes occupancy and an overflow flag for debug.

Parameters:
- DEPTH_LOG2, 10, log2 of entries per FIFO (TX and RX each hold 2**DEPTH_LOG2 bytes).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- out_issued  input  1  core requests a byte write this cycle; held while out_stall=1.
- out_data  input  32  core write data; only [7:0] is stored.
- out_stall  output  1  core must hold the write.
- in_issued  input  1  core requests a byte read this cycle; held while in_stall=1.
- in_stall  output  1  core must hold the read.
- in_data  output  32  zero-extended RX head byte; valid when in_issued=1 and in_stall=0.
- tx_data  output  8  byte to UART transmitter.
- tx_valid  output  1  TX FIFO non-empty.
- tx_ready  input  1  transmitter accepts tx_data this cycle.
- rx_data  input  8  byte from UART receiver.
- rx_valid  input  1  one-cycle strobe; the receiver has no backpressure.
- io_status  output  32  [DEPTH_LOG2:0] RX count, [DEPTH_LOG2+16:16] TX count, [31] rx_overflow.

Behaviour:
- Reset (rst=0, async):
  - both FIFOs empty, pointers and counts = 0;
  - rx_overflow = 0; out_stall = 0; in_stall = 0; tx_valid = 0; in_data = 0; io_status = 0.
  - Reset mid-transfer discards all buffered bytes, with no partial output.
- FIFO core (sync_fifo):
  - circular buffer with DEPTH_LOG2-bit read/write pointers that wrap modulo depth;
  - count is DEPTH_LOG2+1 bits, so full = (count == 2**DEPTH_LOG2) and empty = (count == 0);
  - first-word-fall-through: the head is visible combinationally from a registered head;
  - a byte written into an empty FIFO is poppable the next cycle (1-cycle write-to-read latency).
- Core write:
  - out_stall = out_issued & tx_full (combinational).
  - Push out_data[7:0] on the edge where out_issued=1 and out_stall=0.
- Core read:
  - in_stall = in_issued & rx_empty (combinational).
  - in_data = {24'b0, rx_head} whenever rx is non-empty; 0 when empty.
  - Pop on the edge where in_issued=1 and in_stall=0.
- TX drain:
  - tx_valid = !tx_empty; tx_data = tx_head.
  - Pop on tx_valid & tx_ready. tx_data must stay stable while tx_valid=1 and tx_ready=0.
- RX fill:
  - Push rx_data when rx_valid=1 and not full.
  - rx_valid while full drops the byte and sets rx_overflow. rx_overflow is sticky until reset.
- Simultaneous push and pop on the same FIFO in one cycle:
  - count unchanged, both pointers advance.
  - When full, the pop makes no space for a same-cycle push: the push is refused (TX stalls, RX overflows).
  - When empty, no pop occurs because the head is not yet valid; the push completes.
- Stall signals never depend on tx_ready or rx_valid in the same cycle, so there is no combinational path from the UART side to the core.
- io_status reflects registered counts (post-edge values).

Decomposition:
- Shared package io_pkg holds:
  - IO_DEPTH_LOG2_DEFAULT;
  - io_status bit positions (RX_CNT_LSB = 0, TX_CNT_LSB = 16, OVF_BIT = 31).
- One sub-module, sync_fifo:
  - parameters WIDTH = 8 and DEPTH_LOG2;
  - ports push, pop, din, dout, full, empty, count;
  - instantiated twice (tx_fifo, rx_fifo).
- io_buffer itself contains only the stall logic, the overflow flag and the status packing.

Test Plan:
- Reset then idle: io_status = 0, tx_valid = 0. in_issued=1 -> in_stall=1 each cycle until rx_valid delivers 0x41; one cycle later in_stall=0, in_data=0x00000041, then the FIFO is empty again.
- Burst of out_issued with out_data = 0x12345678, 0xAA, 0x55 and tx_ready=1 every other cycle -> tx_data sequence 0x78, 0xAA, 0x55 in order; TX count returns to 0.
- DEPTH_LOG2=2, tx_ready=0, five writes -> first four accepted; fifth sees out_stall=1 until tx_ready=1 for one cycle, then is accepted; final TX count = 4.
- DEPTH_LOG2=2, five rx_valid strobes 0x01..0x05, no reads -> RX count 4, io_status[31]=1; core reads return 0x01..0x04 and the fifth read stalls.
- Full RX FIFO with a simultaneous rx_valid and core pop in one cycle -> incoming byte dropped, overflow set, count goes from 4 to 3. Empty FIFO with a simultaneous push and read -> read stalls that cycle and succeeds the next.
- Assert rst=0 asynchronously mid-burst with TX count 3 -> tx_valid and io_status drop immediately; after release, tx_valid stays 0 and no stale byte appears.
